// File: rtl/hps_hs_pkg.sv
// Shared types and constants for the FPGA/HPS token handshake controller.
package hps_hs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RAISE   = 3'd1,
        ST_DROP    = 3'd2,
        ST_DONE    = 3'd3,
        ST_RECOVER = 3'd4
    } hs_state_e;

    localparam int unsigned      ERR_W   = 8;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    function automatic logic [ERR_W-1:0] err_sat_inc(input logic [ERR_W-1:0] v);
        return (v == ERR_MAX) ? v : v + ERR_W'(1);
    endfunction

endpackage

// File: rtl/hs_phase_timer.sv
// Per-phase cycle counter; expired flags the last allowed cycle of a phase.
module hs_phase_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned   CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TC = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign expired = enable && (r_cnt == TC);

endmodule

// File: rtl/fpga_hps_handshake_ctrl.sv
// Token handshake with the HPS over a PIO pair: raise flag, wait ack high, wait ack low.
//   state   | meaning
//   IDLE    | waiting for start, flag low
//   RAISE   | flag high, waiting for hps_ack=1
//   DROP    | flag low, waiting for hps_ack=0
//   DONE    | one-cycle completion pulse
//   RECOVER | after abort/timeout, waiting for hps_ack=0
module fpga_hps_handshake_ctrl
    import hps_hs_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic             hps_ack,
    output logic             flag_out,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [CNT_W-1:0] round_count,
    output logic [ERR_W-1:0] err_count
);
    hs_state_e        r_state;
    hs_state_e        w_state_nxt;
    logic             w_expired;
    logic             w_phase_en;
    logic             w_phase_clr;
    logic             w_to_evt;
    logic             w_err_evt;
    logic             w_done_evt;
    logic             r_flag_out;
    logic             r_timeout;
    logic [CNT_W-1:0] r_round_cnt;
    logic [ERR_W-1:0] r_err_cnt;

    hs_phase_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_phase_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (w_phase_clr),
        .enable (w_phase_en),
        .expired(w_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // abort outranks the exit condition, which outranks the terminal count
    always_comb begin
        w_state_nxt = r_state;
        w_to_evt    = 1'b0;
        w_err_evt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (hps_ack) w_err_evt   = 1'b1;
                    else         w_state_nxt = ST_RAISE;
                end
            end
            ST_RAISE: begin
                if (abort) begin
                    w_state_nxt = ST_RECOVER;
                    w_err_evt   = 1'b1;
                end else if (hps_ack) begin
                    w_state_nxt = ST_DROP;
                end else if (w_expired) begin
                    w_state_nxt = ST_RECOVER;
                    w_to_evt    = 1'b1;
                    w_err_evt   = 1'b1;
                end
            end
            ST_DROP: begin
                if (abort) begin
                    w_state_nxt = ST_RECOVER;
                    w_err_evt   = 1'b1;
                end else if (!hps_ack) begin
                    w_state_nxt = ST_DONE;
                end else if (w_expired) begin
                    w_state_nxt = ST_RECOVER;
                    w_to_evt    = 1'b1;
                    w_err_evt   = 1'b1;
                end
            end
            ST_DONE:    w_state_nxt = ST_IDLE;
            ST_RECOVER: if (!hps_ack) w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = (r_state != ST_IDLE);
        done        = (r_state == ST_DONE);
        w_phase_en  = (r_state == ST_RAISE) || (r_state == ST_DROP);
        w_phase_clr = (w_state_nxt != r_state) &&
                      ((w_state_nxt == ST_RAISE) || (w_state_nxt == ST_DROP));
        w_done_evt  = (r_state == ST_DROP) && (w_state_nxt == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flag_out  <= 1'b0;
            r_timeout   <= 1'b0;
            r_round_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_flag_out <= (w_state_nxt == ST_RAISE);
            r_timeout  <= w_to_evt;
            if (w_done_evt) r_round_cnt <= r_round_cnt + CNT_W'(1);
            if (w_err_evt)  r_err_cnt   <= err_sat_inc(r_err_cnt);
        end
    end

    assign flag_out    = r_flag_out;
    assign timeout     = r_timeout;
    assign round_count = r_round_cnt;
    assign err_count   = r_err_cnt;

endmodule

// File: tb/tb_fpga_hps_handshake_ctrl.sv
// Randomized and directed checks of the handshake controller against a phase-window model.
module tb_fpga_hps_handshake_ctrl;

    localparam int TO_CYC   = 8;
    localparam int CW       = 4;
    localparam int TRIP_LEN = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          hps_ack = 1'b0;
    logic          flag_out;
    logic          busy;
    logic          done;
    logic          timeout;
    logic [CW-1:0] round_count;
    logic [7:0]    err_count;

    int n_tests = 0;
    int n_fail  = 0;
    int m_round = 0;
    int m_err   = 0;

    fpga_hps_handshake_ctrl #(
        .TIMEOUT_CYCLES(TO_CYC),
        .CNT_W         (CW)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .hps_ack    (hps_ack),
        .flag_out   (flag_out),
        .busy       (busy),
        .done       (done),
        .timeout    (timeout),
        .round_count(round_count),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One handshake attempt, cycle 0 = start cycle. hps_ack is high for cycles [r, f),
    // abort pulses at cycle ab (-1 = never). Expected behaviour comes from the phase
    // windows: RAISE spans cycles 1..TO_CYC, DROP spans TO_CYC cycles from its entry.
    task automatic do_trip(input string tag, input int r, input int f, input int ab,
                           input bit use_sp);
        int raise_end, x, d, last, c, sp;
        int exp_done_cyc, exp_to_cyc, exp_idle;
        bit err_evt;
        int obs_flag_first, obs_flag_n, obs_done_cyc, obs_done_n;
        int obs_to_cyc, obs_to_n, obs_idle;

        exp_done_cyc = -1;
        exp_to_cyc   = -1;
        err_evt      = 1'b0;
        x            = 0;
        if (ab >= 1 && ab <= TO_CYC && ab <= r) begin
            raise_end = ab;
            x         = ab;
            err_evt   = 1'b1;
        end else if (r <= TO_CYC) begin
            raise_end = r;
            d         = r + 1;
            last      = d + TO_CYC - 1;
            if (ab >= d && ab <= last && ab <= f) begin
                x       = ab;
                err_evt = 1'b1;
            end else if (f <= last) begin
                exp_done_cyc = f + 1;
            end else begin
                x          = last;
                exp_to_cyc = last + 1;
                err_evt    = 1'b1;
            end
        end else begin
            raise_end  = TO_CYC;
            x          = TO_CYC;
            exp_to_cyc = TO_CYC + 1;
            err_evt    = 1'b1;
        end
        if (err_evt) begin
            c = x + 1;
            while (c >= r && c < f) c++;
            exp_idle = c + 1;
        end else begin
            exp_idle = exp_done_cyc + 1;
        end
        sp = use_sp ? 1 + int'($urandom_range(0, exp_idle - 2)) : -1;

        obs_flag_first = -1;
        obs_flag_n     = 0;
        obs_done_cyc   = -1;
        obs_done_n     = 0;
        obs_to_cyc     = -1;
        obs_to_n       = 0;
        obs_idle       = -1;
        for (int t = 0; t < TRIP_LEN; t++) begin
            if (flag_out) begin
                obs_flag_n++;
                if (obs_flag_first < 0) obs_flag_first = t;
            end
            if (done) begin
                obs_done_n++;
                if (obs_done_cyc < 0) obs_done_cyc = t;
            end
            if (timeout) begin
                obs_to_n++;
                if (obs_to_cyc < 0) obs_to_cyc = t;
            end
            if (t > 0 && !busy && obs_idle < 0) obs_idle = t;
            start   = (t == 0) || (t == sp);
            hps_ack = (t >= r) && (t < f);
            abort   = (t == ab);
            step();
        end
        start   = 1'b0;
        hps_ack = 1'b0;
        abort   = 1'b0;

        if (err_evt) m_err = (m_err >= 255) ? 255 : m_err + 1;
        else         m_round = (m_round + 1) % (1 << CW);

        n_tests++;
        if (obs_flag_first !== 1) begin
            n_fail++;
            $display("FAIL %s flag_rise_cycle: got %0d expected 1", tag, obs_flag_first);
        end
        n_tests++;
        if (obs_flag_n !== raise_end) begin
            n_fail++;
            $display("FAIL %s flag_high_cycles: got %0d expected %0d", tag, obs_flag_n, raise_end);
        end
        n_tests++;
        if (obs_done_cyc !== exp_done_cyc || obs_done_n !== (exp_done_cyc >= 0 ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s done_pulse: got cycle %0d count %0d expected cycle %0d",
                     tag, obs_done_cyc, obs_done_n, exp_done_cyc);
        end
        n_tests++;
        if (obs_to_cyc !== exp_to_cyc || obs_to_n !== (exp_to_cyc >= 0 ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s timeout_pulse: got cycle %0d count %0d expected cycle %0d",
                     tag, obs_to_cyc, obs_to_n, exp_to_cyc);
        end
        n_tests++;
        if (obs_idle !== exp_idle) begin
            n_fail++;
            $display("FAIL %s idle_cycle: got %0d expected %0d", tag, obs_idle, exp_idle);
        end
        n_tests++;
        if (round_count !== m_round[CW-1:0]) begin
            n_fail++;
            $display("FAIL %s round_count: got %0d expected %0d", tag, round_count, m_round);
        end
        n_tests++;
        if (err_count !== m_err[7:0]) begin
            n_fail++;
            $display("FAIL %s err_count: got %0d expected %0d", tag, err_count, m_err);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        n_tests++;
        if ({flag_out, busy, done, timeout} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", {flag_out, busy, done, timeout});
        end
        n_tests++;
        if (round_count !== '0 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_counts: got round %0d err %0d expected 0 0", round_count, err_count);
        end
        reset_n = 1'b1;
        step();
        n_tests++;
        if ({flag_out, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b expected 00", {flag_out, busy});
        end
        m_round = 0;
        m_err   = 0;
    endtask

    task automatic test_normal_round_trip();
        do_trip("normal", 4, 7, -1, 1'b0);
    endtask

    task automatic test_raise_timeout();
        do_trip("raise_timeout", 1000, 1000, -1, 1'b0);
    endtask

    task automatic test_terminal_count_ties();
        do_trip("raise_tie", TO_CYC, TO_CYC + 2, -1, 1'b0);
        do_trip("drop_tie", 3, 4 + TO_CYC - 1, -1, 1'b0);
        do_trip("drop_timeout", 3, 4 + TO_CYC, -1, 1'b0);
        do_trip("abort_vs_ack", 5, 8, 5, 1'b0);
    endtask

    task automatic test_rejected_start();
        hps_ack = 1'b1;
        start   = 1'b1;
        step();
        start   = 1'b0;
        m_err   = (m_err >= 255) ? 255 : m_err + 1;
        n_tests++;
        if ({flag_out, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL rejected_start_state: got flag/busy %b expected 00", {flag_out, busy});
        end
        step();
        n_tests++;
        if (err_count !== m_err[7:0] || flag_out !== 1'b0) begin
            n_fail++;
            $display("FAIL rejected_start_err: got err %0d flag %b expected err %0d flag 0",
                     err_count, flag_out, m_err);
        end
        hps_ack = 1'b0;
        step();
    endtask

    task automatic test_start_while_busy();
        do_trip("start_busy", 5, 9, -1, 1'b1);
        do_trip("start_busy_to", 1000, 1000, -1, 1'b1);
    endtask

    task automatic test_abort();
        abort = 1'b1;
        step();
        abort = 1'b0;
        step();
        n_tests++;
        if (busy !== 1'b0 || err_count !== m_err[7:0]) begin
            n_fail++;
            $display("FAIL abort_idle: got busy %b err %0d expected busy 0 err %0d",
                     busy, err_count, m_err);
        end
        do_trip("abort_drop", 2, 9, 4, 1'b0);
        do_trip("abort_raise", 6, 10, 2, 1'b0);
        do_trip("abort_recover", 1000, 1000, 11, 1'b0);
        do_trip("abort_at_start", 3, 6, 0, 1'b0);
    endtask

    task automatic test_random();
        int r, f, ab;
        for (int i = 0; i < 40; i++) begin
            r  = int'($urandom_range(1, 10));
            f  = r + 1 + int'($urandom_range(0, 9));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
            do_trip($sformatf("rand%0d", i), r, f, ab, bit'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_reset_mid_raise();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        n_tests++;
        if (flag_out !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_pre_flag: got %b expected 1", flag_out);
        end
        #1;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({flag_out, busy, done, timeout} !== 4'b0000) begin
            n_fail++;
            $display("FAIL midreset_async_flags: got %b expected 0000",
                     {flag_out, busy, done, timeout});
        end
        n_tests++;
        if (round_count !== '0 || err_count !== 8'd0) begin
            n_fail++;
            $display("FAIL midreset_counts: got round %0d err %0d expected 0 0",
                     round_count, err_count);
        end
        step();
        step();
        reset_n = 1'b1;
        m_round = 0;
        m_err   = 0;
        step();
        do_trip("post_reset", 2, 4, -1, 1'b0);
    endtask

    task automatic test_err_saturation();
        for (int i = 0; i < 260; i++) begin
            do_trip($sformatf("sat%0d", i), 1000, 1000, -1, 1'b0);
        end
        n_tests++;
        if (err_count !== 8'd255) begin
            n_fail++;
            $display("FAIL err_saturation: got %0d expected 255", err_count);
        end
    endtask

    initial begin
        test_reset();
        test_normal_round_trip();
        test_raise_timeout();
        test_terminal_count_ties();
        test_rejected_start();
        test_start_while_busy();
        test_abort();
        test_random();
        test_reset_mid_raise();
        test_err_saturation();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
